// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and write-back entry type.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first search of pending write-back entries for one read address.
module wb_fwd_match
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      head,
    input  logic [CNT_W-1:0]      cnt,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [REG_DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (CNT_W'(k) < cnt && entries[idx].valid &&
                entries[idx].addr == addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue in front of the register file write port,
// with forwarding of the youngest pending value for two read ports.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_reg,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       wb_stall,
    output logic                       reg_write,
    output logic [ADDR_W-1:0]          write_reg,
    output logic [DATA_W-1:0]          write_data,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic                       fwd_hit1,
    output logic [DATA_W-1:0]          fwd_data1,
    output logic                       fwd_hit2,
    output logic [DATA_W-1:0]          fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  push;
    logic                  pop;
    logic                  busy;

    assign busy      = (count != '0);
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = busy && !wb_stall;
    assign reg_write = pop;
    assign write_reg  = busy ? entries[head].addr : '0;
    assign write_data = busy ? entries[head].data : '0;

    // Push and pop never target the same slot: that needs count 0 or DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: in_reg, data: in_data};
                tail <= tail + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (entries),
        .head    (head),
        .cnt     (count),
        .addr    (rd_addr1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (entries),
        .head    (head),
        .cnt     (count),
        .addr    (rd_addr2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4).
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_reg = '0;
    logic [31:0] in_data = '0;
    logic        wb_stall = 1'b0;
    logic        reg_write;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .wb_stall   (wb_stall),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_data1  (fwd_data1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data2  (fwd_data2),
        .count      (count)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_stalled(input logic [3:0] r, input logic [31:0] d);
        wb_stall = 1'b1;
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
        checks++; if (reg_write !== 1'b0 || write_reg !== 4'd0 || write_data !== 32'd0) begin
            failures++; $display("FAIL rst_wport got=%0b/%0h/%0h exp=0/0/0", reg_write, write_reg, write_data); end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0 || fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
            failures++; $display("FAIL rst_fwd got=%0b/%0h/%0b/%0h exp=0", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        in_valid = 1'b1; in_reg = 4'd3; in_data = 32'hDEADBEEF; rd_addr1 = 4'd3;
        #1;
        checks++; if (fwd_hit1 !== 1'b0) begin failures++; $display("FAIL single_fwd_early got=%0b exp=0", fwd_hit1); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (reg_write !== 1'b1 || write_reg !== 4'd3 || write_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_wport got=%0b/%0h/%0h exp=1/3/deadbeef", reg_write, write_reg, write_data); end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_fwd_head got=%0b/%0h exp=1/deadbeef", fwd_hit1, fwd_data1); end
        tick();
        checks++; if (count !== 3'd0 || reg_write !== 1'b0) begin
            failures++; $display("FAIL single_after got=%0d/%0b exp=0/0", count, reg_write); end
    endtask

    task automatic test_full_stall;
        for (int i = 1; i <= 4; i++) push_stalled(4'(i), 32'(i * 'h11));
        checks++; if (count !== 3'd4 || in_ready !== 1'b0 || reg_write !== 1'b0) begin
            failures++; $display("FAIL full_state got=%0d/%0b/%0b exp=4/0/0", count, in_ready, reg_write); end
        rd_addr1 = 4'd2;
        #1;
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
            failures++; $display("FAIL full_fwd got=%0b/%0h exp=1/22", fwd_hit1, fwd_data1); end
        push_stalled(4'd9, 32'h99);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_refuse got=%0d exp=4", count); end
        wb_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (reg_write !== 1'b1 || write_reg !== 4'(i) || write_data !== 32'(i * 'h11)) begin
                failures++; $display("FAIL full_drain%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i, reg_write, write_reg, write_data, i, i * 'h11); end
            tick();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", count); end
    endtask

    task automatic test_fwd;
        push_stalled(4'd5, 32'hA);
        in_valid = 1'b1; in_reg = 4'd5; in_data = 32'hB; rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        #1;
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hA) begin
            failures++; $display("FAIL fwd_samecyc got=%0b/%0h exp=1/a", fwd_hit1, fwd_data1); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hB) begin
            failures++; $display("FAIL fwd_young got=%0b/%0h exp=1/b", fwd_hit1, fwd_data1); end
        checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
            failures++; $display("FAIL fwd_miss got=%0b/%0h exp=0/0", fwd_hit2, fwd_data2); end
        wb_stall = 1'b0;
        tick();
        #1;
        checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hB || write_data !== 32'hB) begin
            failures++; $display("FAIL fwd_head got=%0b/%0h/%0h exp=1/b/b", fwd_hit1, fwd_data1, write_data); end
        tick();
        checks++; if (count !== 3'd0 || fwd_hit1 !== 1'b0) begin
            failures++; $display("FAIL fwd_empty got=%0d/%0b exp=0/0", count, fwd_hit1); end
    endtask

    task automatic test_full_unstall;
        for (int i = 0; i < 4; i++) push_stalled(4'(8 + i), 32'h100 + 32'(i));
        wb_stall = 1'b0; in_valid = 1'b1; in_reg = 4'd12; in_data = 32'h200;
        #1;
        checks++; if (in_ready !== 1'b0 || reg_write !== 1'b1 || write_reg !== 4'd8) begin
            failures++; $display("FAIL fu_edge got=%0b/%0b/%0h exp=0/1/8", in_ready, reg_write, write_reg); end
        tick();
        checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin
            failures++; $display("FAIL fu_nopush got=%0d/%0b exp=3/1", count, in_ready); end
        for (int i = 0; i < 2; i++) begin
            in_reg = 4'(12 + i); in_data = 32'h200 + 32'(i);
            #1;
            checks++; if (write_reg !== 4'(9 + i)) begin
                failures++; $display("FAIL fu_order%0d got=%0h exp=%0h", i, write_reg, 9 + i); end
            tick();
            checks++; if (count !== 3'd3) begin failures++; $display("FAIL fu_hold%0d got=%0d exp=3", i, count); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (write_reg !== 4'(11 + i) || write_data !== (i == 0 ? 32'h103 : 32'h200 + 32'(i - 1))) begin
                failures++; $display("FAIL fu_drain%0d got=%0h/%0h exp=%0h", i, write_reg, write_data, 11 + i); end
            tick();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fu_empty got=%0d exp=0", count); end
    endtask

    task automatic test_wrap;
        int sent = 0;
        int got = 0;
        int mcount = 0;
        bit pushed;
        bit popped;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            wb_stall = (cyc % 3 == 1);
            in_valid = (sent < 8);
            in_reg   = 4'(sent);
            in_data  = 32'h1000 + 32'(sent);
            #1;
            checks++; if (in_ready !== (mcount < 4) || reg_write !== (mcount != 0 && !wb_stall)) begin
                failures++; $display("FAIL wrap_hs c%0d got=%0b/%0b exp=%0b/%0b", cyc, in_ready, reg_write, mcount < 4, mcount != 0 && !wb_stall); end
            popped = (mcount != 0 && !wb_stall);
            pushed = (sent < 8 && mcount < 4);
            if (popped) begin
                checks++; if (write_reg !== 4'(got) || write_data !== 32'h1000 + 32'(got)) begin
                    failures++; $display("FAIL wrap_wr%0d got=%0h/%0h exp=%0h/%0h", got, write_reg, write_data, got, 32'h1000 + got); end
                got++;
            end
            if (pushed) sent++;
            mcount = mcount + int'(pushed) - int'(popped);
            tick();
        end
        in_valid = 1'b0;
        wb_stall = 1'b0;
        checks++; if (got != 8 || count !== 3'd0) begin
            failures++; $display("FAIL wrap_done got=%0d/%0d exp=8/0", got, count); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) push_stalled(4'(i + 1), 32'h50 + 32'(i));
        wb_stall = 1'b0; rd_addr1 = 4'd2; rd_addr2 = 4'd3;
        #1;
        checks++; if (reg_write !== 1'b1 || count !== 3'd3 || fwd_hit1 !== 1'b1) begin
            failures++; $display("FAIL rm_pre got=%0b/%0d/%0b exp=1/3/1", reg_write, count, fwd_hit1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (reg_write !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rm_async got=%0b/%0d/%0b exp=0/0/1", reg_write, count, in_ready); end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || write_reg !== 4'd0) begin
            failures++; $display("FAIL rm_fwd got=%0b/%0b/%0h exp=0/0/0", fwd_hit1, fwd_hit2, write_reg); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (count !== 3'd0 || reg_write !== 1'b0) begin
            failures++; $display("FAIL rm_after got=%0d/%0b exp=0/0", count, reg_write); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_stall();
        test_fwd();
        test_full_unstall();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
